// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: valid/ready operation and result bus for alu_exec_stage.
interface alu_exec_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alucont;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       dest_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       dest_out;
  logic [3:0]       flags;
  logic             illegal_op;
  modport master (
    output in_valid, alucont, srca, srcb, dest_in, out_ready,
    input  in_ready, out_valid, result, dest_out, flags, illegal_op
  );
  modport slave (
    input  in_valid, alucont, srca, srcb, dest_in, out_ready,
    output in_ready, out_valid, result, dest_out, flags, illegal_op
  );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: latency-1 ALU stage with valid/ready handshake and sticky illegal-op flag.
// Define ALU_FLAGS_EN to build the {C, F, Z, N} flag register; otherwise flags read 0000.
module alu_exec_stage #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            reset,
  alu_exec_stage_if.slave bus
);
  logic             acc, legal, valid_q, illegal_q;
  logic [WIDTH-1:0] a, b, res_d, res_q;
  logic [3:0]       dest_q;
  assign a = bus.srca;
  assign b = bus.srcb;
  assign legal = bus.alucont < 3'd5;
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign acc = bus.in_valid && bus.in_ready;
`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum, dif;
  logic           arith, c_d, f_d;
  logic [3:0]     flags_q;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign arith = bus.alucont[2:1] == 2'b00;
`else
  logic [WIDTH-1:0] sum, dif;
  assign sum = a + b;
  assign dif = a - b;
`endif
  always_comb begin
    res_d = bus.alucont == 3'd0 ? sum[WIDTH-1:0] :
            bus.alucont == 3'd1 ? dif[WIDTH-1:0] :
            bus.alucont == 3'd2 ? a & b :
            bus.alucont == 3'd3 ? a ^ b :
            bus.alucont == 3'd4 ? a | b : '0;
  end
`ifdef ALU_FLAGS_EN
  // Borrow of sub is the top bit of the widened difference, i.e. srca < srcb unsigned.
  always_comb begin
    c_d = bus.alucont[0] ? dif[WIDTH] : sum[WIDTH];
    f_d = (bus.alucont[0] ? a[WIDTH-1] != b[WIDTH-1] : a[WIDTH-1] == b[WIDTH-1]) &&
          res_d[WIDTH-1] != a[WIDTH-1];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) flags_q <= 4'b0000;
    else if (acc && legal)
      flags_q <= {arith ? c_d : flags_q[3], arith ? f_d : flags_q[2], res_d == '0, res_d[WIDTH-1]};
  assign bus.flags = flags_q;
`else
  assign bus.flags = 4'b0000;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      res_q     <= '0;
      dest_q    <= '0;
    end else begin
      valid_q   <= acc || (valid_q && !bus.out_ready);
      illegal_q <= illegal_q || (acc && !legal);
      if (acc) begin
        res_q  <= res_d;
        dest_q <= bus.dest_in;
      end
    end
  assign bus.out_valid  = valid_q;
  assign bus.result     = res_q;
  assign bus.dest_out   = dest_q;
  assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed self-checking bench for alu_exec_stage (either ALU_FLAGS_EN build).
module tb_alu_exec_stage;
`ifdef ALU_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  alu_exec_stage_if #(.WIDTH(16)) bus ();
  alu_exec_stage #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.alucont  = c;
    bus.srca     = a;
    bus.srcb     = b;
    bus.dest_in  = d;
  endtask
  function automatic logic [3:0] fx(input logic [3:0] f);
    return FE ? f : 4'b0000;
  endfunction
  initial begin
    reset = 1'b0;
    bus.out_ready = 1'b1;
    op(3'd0, 16'h1234, 16'h1111, 4'hA);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_dest", bus.dest_out, 0);
    chk("rst_flags", bus.flags, 0);
    chk("rst_illegal", bus.illegal_op, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    #2 reset = 1'b1;
    op(3'd0, 16'hFFFF, 16'h0001, 4'h3);
    tick();
    chk("add_valid", bus.out_valid, 1);
    chk("add_result", bus.result, 16'h0000);
    chk("add_dest", bus.dest_out, 4'h3);
    chk("add_flags", bus.flags, fx(4'b1010));
    op(3'd1, 16'h8000, 16'h0001, 4'h5);
    tick();
    chk("sub_result", bus.result, 16'h7FFF);
    chk("sub_flags", bus.flags, fx(4'b0100));
    op(3'd2, 16'h00F0, 16'h0F00, 4'h6);
    tick();
    chk("and_result", bus.result, 16'h0000);
    chk("and_flags", bus.flags, fx(4'b0110));
    bus.out_ready = 1'b0;
    op(3'd0, 16'h0001, 16'h0002, 4'h7);
    #1;
    chk("stall_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_result", bus.result, 16'h0000);
      chk("stall_dest", bus.dest_out, 4'h6);
      chk("stall_flags", bus.flags, fx(4'b0110));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", bus.in_ready, 1);
    tick();
    chk("unstall_valid", bus.out_valid, 1);
    chk("unstall_result", bus.result, 16'h0003);
    chk("unstall_dest", bus.dest_out, 4'h7);
    chk("unstall_flags", bus.flags, fx(4'b0000));
    bus.in_valid = 1'b0;
    bus.alucont = 3'd3;
    bus.srca = 16'hDEAD;
    tick();
    chk("drain_valid", bus.out_valid, 0);
    chk("idle_result", bus.result, 16'h0003);
    for (int i = 0; i < 8; i++) begin
      op(3'd0, 16'(i), 16'h0100, 4'(i));
      tick();
      chk("b2b_valid", bus.out_valid, 1);
      chk("b2b_result", bus.result, 16'h0100 + 16'(i));
      chk("b2b_dest", bus.dest_out, 4'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_drain", bus.out_valid, 0);
    op(3'd1, 16'h0000, 16'h0001, 4'h8);
    tick();
    chk("borrow_result", bus.result, 16'hFFFF);
    chk("borrow_flags", bus.flags, fx(4'b1001));
    op(3'b110, 16'h0005, 16'h0005, 4'h9);
    tick();
    chk("ill_valid", bus.out_valid, 1);
    chk("ill_result", bus.result, 16'h0000);
    chk("ill_dest", bus.dest_out, 4'h9);
    chk("ill_flags", bus.flags, fx(4'b1001));
    chk("ill_flag", bus.illegal_op, 1);
    for (int i = 0; i < 10; i++) begin
      op(3'd4, 16'(i), 16'h0000, 4'h1);
      tick();
    end
    chk("ill_held", bus.illegal_op, 1);
    chk("or_result", bus.result, 16'h0009);
    chk("or_flags", bus.flags, fx(4'b1000));
    bus.out_ready = 1'b0;
    op(3'd0, 16'h0002, 16'h0002, 4'h2);
    tick();
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_illegal", bus.illegal_op, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_flags", bus.flags, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("postrst_in_ready", bus.in_ready, 1);
    tick();
    chk("postrst_valid", bus.out_valid, 1);
    chk("postrst_result", bus.result, 16'h0004);
    chk("postrst_dest", bus.dest_out, 4'h2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream has an operation.
REQ-005 SHALL have port in_ready  output  1  stage can accept an operation this cycle.
REQ-006 SHALL have port alucont  input  3  op select: 000 add, 001 sub, 010 and, 011 xor, 100 or; 101-111 illegal.
REQ-007 SHALL have port srca / srcb  input  WIDTH each  operands.
REQ-008 SHALL have port dest_in  input  4  destination register tag.
REQ-009 SHALL have port out_valid  output  1  registered result is present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port result / dest_out  output  WIDTH / 4  registered result and tag.
REQ-012 SHALL have port flags  output  4  registered {C, F, Z, N}.
REQ-013 SHALL have port illegal_op  output  1  sticky error flag.

Function
REQ-014 SHALL accept an operation when in_valid && in_ready; result, dest_out and flags SHALL be visible with out_valid high exactly one cycle later (latency 1).
REQ-015 SHALL drive in_ready = !out_valid || out_ready (combinational), giving full throughput with no bubble under continuous out_ready.
REQ-016 SHALL hold result, dest_out, flags and out_valid stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid on out_valid && out_ready when no new operation is accepted in the same cycle; simultaneous drain and accept SHALL keep out_valid high with the new data.
REQ-018 SHALL compute add as srca+srcb and sub as srca-srcb, truncated to WIDTH bits; and/xor/or are bitwise.
REQ-019 SHALL set C to the carry-out for add and to the borrow (srca < srcb unsigned) for sub.
REQ-020 SHALL set F to signed overflow for add/sub (operand signs equal for add, differing for sub, and result sign differs from srca).
REQ-021 SHALL set Z = (result == 0) and N = result[WIDTH-1] for every legal accepted op.
REQ-022 SHALL leave C and F unchanged on accepted and/xor/or.
REQ-023 SHALL, on an accepted illegal alucont, register result = 0, leave all flags unchanged, still pass dest_out and assert out_valid, and set illegal_op.
REQ-024 SHALL keep illegal_op set until reset; no other event clears it.
REQ-025 SHALL ignore alucont, srca, srcb, dest_in while in_valid is low or in_ready is low.

Reset
REQ-026 SHALL, while reset is low, asynchronously force out_valid=0, result=0, dest_out=0, flags=0000, illegal_op=0.
REQ-027 SHALL discard any held result when reset asserts mid-operation; in_ready SHALL read 1 during and immediately after reset.
REQ-028 SHALL accept a new operation on the first rising clk edge after reset deasserts.

Configuration
REQ-029 SHALL, with macro ALU_FLAGS_EN defined, implement the flag register and behaviour of REQ-019..REQ-023.
REQ-030 SHALL, without ALU_FLAGS_EN, contain no flag register and drive flags constant 0000; all other behaviour unchanged.

Verification
REQ-031 SHALL cover: add srca=16'hFFFF srcb=16'h0001 -> next cycle result=16'h0000, flags C=1 F=0 Z=1 N=0.
REQ-032 SHALL cover: sub srca=16'h8000 srcb=16'h0001 -> result=16'h7FFF, C=0 F=1 Z=0 N=0; then and 16'h00F0 & 16'h0F00 -> result 0, C=0 F=1 retained, Z=1.
REQ-033 SHALL cover: out_ready low for 3 cycles with in_valid high -> in_ready=0, outputs stable, second op accepted on the cycle out_ready rises, out_valid stays 1.
REQ-034 SHALL cover: continuous in_valid/out_ready with 8 back-to-back ops -> 8 results on 8 consecutive cycles, in order, dest tags matching.
REQ-035 SHALL cover: alucont=3'b110 -> result=0, flags unchanged, illegal_op=1 and held after 10 further legal ops; reset low mid-stall -> out_valid=0, illegal_op=0 immediately.
REQ-036 SHALL cover: build without ALU_FLAGS_EN, rerun REQ-031 -> result 16'h0000, flags=0000.
